// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// FSM state enum, default geometry, even-parity helper.
package regfile_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;
  // Widest data word the parity helper accepts.
  localparam int RF_PW    = 128;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Even parity: the bit that makes data+parity hold an even
  // number of ones. Narrower words are zero-extended by callers.
  function automatic logic par_even(input logic [RF_PW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: reset/busy gating, r0 hardwire,
// write bypass (port 1 over port 0), array read, parity check.
// Macro REGFILE_PARITY_EN adds the stored-parity input and perr.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = 5
) (
  input  logic          rst,
  input  logic          busy,
  input  logic          ready,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          we0,
  input  logic [AW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] rd,
`ifdef REGFILE_PARITY_EN
  input  logic          rpar,
`endif
  output logic [DW-1:0] rdata,
  output logic          perr
);

  logic hit1;
  logic hit0;
  logic live;

  assign hit1 = ready && we1 && (waddr1 == raddr);
  assign hit0 = ready && we0 && (waddr0 == raddr);
  assign live = !rst && !busy && re && (raddr != '0);

  // Ordered priority: overlapping conditions are intended.
  always_comb begin
    rdata = '0;
    if (rst || busy) begin
      rdata = '0;
    end else if (!re) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
    end else if (hit1) begin
      rdata = wdata1;
    end else if (hit0) begin
      rdata = wdata0;
    end else begin
      rdata = rd;
    end
  end

`ifdef REGFILE_PARITY_EN
  always_comb begin
    perr = 1'b0;
    if (live && ready && !hit1 && !hit0) begin
      perr = par_even(RF_PW'(rd)) != rpar;
    end
  end
`else
  logic unused_live;
  assign unused_live = live;
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Dual-write, NRD-read register file with bypass and
// post-reset clear sweep (init_busy high while sweeping).
// Ports: clk, rst, we0/waddr0/wdata0, we1/waddr1/wdata1
// (port 1 is younger and wins collisions), re, raddr (packed),
// rdata (packed), init_busy, perr. Macro REGFILE_PARITY_EN
// stores a parity bit per entry and drives perr.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic              init_busy,
  output logic [NRD-1:0]    perr
);

  rf_state_e     state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] regs [DEPTH];

  logic ready;
  logic sweep;
  logic wr0_ok;
  logic wr1_ok;

  assign ready = (state == RF_READY);
  assign sweep = !rst && (state == RF_CLEAR);

  // Same-address collision: younger port 1 owns the entry.
  assign wr0_ok = !rst && ready && we0 && (waddr0 != '0)
               && !(we1 && (waddr1 == waddr0));
  assign wr1_ok = !rst && ready && we1 && (waddr1 != '0);

  // Entry 0 is never touched, so the sweep starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_CLEAR;
      ptr       <= AW'(1);
      init_busy <= 1'b1;
    end else if (state == RF_CLEAR) begin
      ptr <= ptr + AW'(1);
      if (ptr == AW'(DEPTH - 1)) begin
        state     <= RF_READY;
        init_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sweep) begin
      regs[ptr] <= '0;
    end else begin
      if (wr0_ok) regs[waddr0] <= wdata0;
      if (wr1_ok) regs[waddr1] <= wdata1;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (sweep) begin
      par[ptr] <= 1'b0;
    end else begin
      if (wr0_ok) par[waddr0] <= par_even(RF_PW'(wdata0));
      if (wr1_ok) par[waddr1] <= par_even(RF_PW'(wdata1));
    end
  end
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    regfile_rdport #(
      .DW (DW),
      .AW (AW)
    ) u_rd (
      .rst    (rst),
      .busy   (init_busy),
      .ready  (ready),
      .re     (re[i]),
      .raddr  (ra),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .rd     (regs[ra]),
`ifdef REGFILE_PARITY_EN
      .rpar   (par[ra]),
`endif
      .rdata  (rdata[i*DW +: DW]),
      .perr   (perr[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DW=32,
// DEPTH=32, NRD=2): sweep, writes, collisions, bypass, parity.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk;
  logic              rst;
  logic              we0;
  logic [AW-1:0]     waddr0;
  logic [DW-1:0]     wdata0;
  logic              we1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic [NRD-1:0]    re;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic              init_busy;
  logic [NRD-1:0]    perr;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .DW    (DW),
    .DEPTH (32),
    .NRD   (NRD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .init_busy (init_busy),
    .perr      (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdp(input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1);
    re    = 2'b11;
    raddr = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic e0, input logic [AW-1:0] a0,
                    input logic [DW-1:0] d0,
                    input logic e1, input logic [AW-1:0] a1,
                    input logic [DW-1:0] d1);
    we0 = e0; waddr0 = a0; wdata0 = d0;
    we1 = e1; waddr1 = a1; wdata1 = d1;
    step();
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  // Releases rst and counts busy cycles; rdata must stay 0.
  task automatic sweep(input string tag);
    int cnt;
    cnt = 0;
    rst = 1'b0;
    re  = 2'b11;
    raddr = {5'd4, 5'd5};
    #1;
    while (init_busy && cnt < 100) begin
      chk({tag, "_rd"}, rdata[31:0] | rdata[63:32], 32'h0);
      step();
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd31);
  endtask

  initial begin
    rst = 1'b1;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    re = '0; raddr = '0;
    step();
    step();
    rdp(5'd3, 5'd5);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_rd0", rdata[31:0], 32'h0);
    chk("rst_rd1", rdata[63:32], 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);

    sweep("por_sweep");
    chk("por_idle", 32'(init_busy), 32'd0);

    wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    rdp(5'd5, 5'd0);
    chk("wr5", rdata[31:0], 32'hDEADBEEF);
    chk("rd_r0", rdata[63:32], 32'h0);
    wr(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    rdp(5'd0, 5'd5);
    chk("wr0", rdata[31:0], 32'h0);
    chk("wr5_p1", rdata[63:32], 32'hDEADBEEF);

    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    rdp(5'd7, 5'd7);
    chk("coll_byp0", rdata[31:0], 32'h22);
    chk("coll_byp1", rdata[63:32], 32'h22);
    step();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    chk("coll_commit", rdata[31:0], 32'h22);

    wr(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    rdp(5'd3, 5'd4);
    chk("dual3", rdata[31:0], 32'h33);
    chk("dual4", rdata[63:32], 32'h44);

    wr(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 32'h0);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hB;
    rdp(5'd9, 5'd9);
    chk("byp_p0", rdata[31:0], 32'hB);
    chk("byp_p1", rdata[63:32], 32'hB);
    re = 2'b01;
    #1;
    chk("byp_re0", rdata[63:32], 32'h0);
    chk("byp_keep", rdata[31:0], 32'hB);
    step();
    we0 = 1'b0;
    rdp(5'd9, 5'd3);
    chk("byp_commit", rdata[31:0], 32'hB);
    chk("hold3", rdata[63:32], 32'h33);

    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h99;
    rdp(5'd4, 5'd3);
    chk("byp1_only", rdata[31:0], 32'h99);
    chk("byp1_other", rdata[63:32], 32'h33);
    step();
    we1 = 1'b0;

    rst = 1'b1;
    step();
    sweep("clr_sweep");
    for (int a = 1; a < 32; a++) begin
      rdp(AW'(a), AW'(a));
      chk($sformatf("clr_r%0d", a), rdata[31:0], 32'h0);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("mid_busy", 32'(init_busy), 32'd1);
    rst = 1'b1;
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h77;
    rdp(5'd12, 5'd12);
    chk("mid_rst_rd", rdata[31:0], 32'h0);
    step();
    we1 = 1'b0;
    sweep("restart_sweep");
    rdp(5'd12, 5'd12);
    chk("mid_drop", rdata[31:0], 32'h0);

    wr(1'b1, 5'd2, 32'h0F, 1'b0, 5'd0, 32'h0);
    rdp(5'd2, 5'd2);
    chk("par_rd", rdata[31:0], 32'h0F);
    chk("par_ok", 32'(perr), 32'h0);
`ifdef REGFILE_PARITY_EN
    dut.regs[2] = 32'h0E;
    #1;
    chk("par_flip", 32'(perr[0]), 32'd1);
    chk("par_data", rdata[31:0], 32'h0E);
`else
    wr(1'b1, 5'd2, 32'h07, 1'b1, 5'd6, 32'h1);
    rdp(5'd2, 5'd6);
    chk("par_off", 32'(perr), 32'h0);
    chk("par_off_rd", rdata[31:0], 32'h07);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read OpenMIPS register file.
- Configurable data width, depth and read-port count; two write ports for dual-issue writeback, with port 1 the younger instruction.
- Write-to-read bypass on every read port.
- After reset, a hardware clear sweep zeroes the array and raises a busy flag until done.
- Sits between the ID stage (read ports) and the WB stage (write ports).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of two and at least 4.
- AW, $clog2(DEPTH), register address width.
- NRD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- we0  in  1  write enable, port 0 (older instruction).
- waddr0  in  AW  write address, port 0.
- wdata0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (younger instruction).
- waddr1  in  AW  write address, port 1.
- wdata1  in  DW  write data, port 1.
- re  in  NRD  per-port read enable.
- raddr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NRD*DW  packed read data; port i occupies bits [i*DW +: DW].
- init_busy  out  1  high while the clear sweep runs.
- perr  out  NRD  per-port parity error (see Optional Feature).

Behaviour:
- FSM states: CLEAR, READY.
- rst=1 at any edge, including mid-sweep or mid-operation: state<=CLEAR, ptr<=1, init_busy<=1.
- CLEAR with rst=0: each edge writes regs[ptr]<=0 and increments ptr.
  - The edge that writes ptr=DEPTH-1 moves the state to READY and clears init_busy.
  - Sweep length from rst deassertion is DEPTH-1 cycles; init_busy is low in cycle DEPTH-1.
- All writes (we0, we1) are discarded while rst=1 or state is CLEAR.
- Writes in READY:
  - Commit on the rising edge.
  - waddr==0 is never written; register 0 always reads 0.
  - we0 and we1 both set with waddr0==waddr1: only wdata1 is stored.
  - Different addresses: both are stored in the same cycle.
- Reads are combinational; there is no registered output. For read port i, the first matching rule applies:
  1. rst=1 or init_busy=1 -> 0.
  2. re[i]=0 -> 0.
  3. raddr_i==0 -> 0.
  4. we1 && waddr1==raddr_i -> wdata1 (bypass).
  5. we0 && waddr0==raddr_i -> wdata0 (bypass).
  6. Otherwise regs[raddr_i].
- Bypass rules 4 and 5 apply only in READY; the same combinational cycle sees the value being written.
- Reset value of all outputs: rdata=0, perr=0, init_busy=1.
- Read ports are mutually independent; any ports may read the same address concurrently.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit, computed from write data; the clear sweep stores parity 0.
  - perr[i] = re[i] && state==READY && raddr_i!=0 && no bypass hit && (^regs[raddr_i] data != stored parity).
  - perr is combinational, reported only, and does not alter rdata.
- Not defined: no parity storage; perr tied to 0.

Decomposition:
- Package regfile_pkg holds:
  - FSM state enum (RF_CLEAR, RF_READY).
  - Default DW/DEPTH constants.
  - A function computing even parity over DW bits.
- One sub-module, regfile_rdport: the per-port priority mux (rules 1-6 plus the perr check), instantiated NRD times via generate.
- The array, write logic and FSM live in regfile_mp.

Test Plan:
- Clear sweep: load nonzero values, pulse rst for 1 cycle.
  - -> init_busy high for exactly 31 cycles (DEPTH=32).
  - -> all rdata=0 throughout.
  - -> afterwards every register reads 0x00000000.
- Basic write/read: we0, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr[0]=5, re[0]=1 -> rdata port0=0xDEADBEEF. Writing address 0 with 0x1234 -> reads 0.
- Dual-write collision: we0=we1=1, both addresses 7, wdata0=0x11, wdata1=0x22.
  - -> same-cycle bypass read of 7 returns 0x22.
  - -> next-cycle read returns 0x22.
  - -> distinct addresses 3 and 4 both commit.
- Bypass: reg 9 holds 0xA; we0=1, waddr0=9, wdata0=0xB; same cycle raddr on ports 0 and 1 = 9 -> both return 0xB. With re[1]=0 -> port1 returns 0.
- Reset mid-sweep and mid-write: rst asserted at sweep cycle 10 with we1=1.
  - -> write dropped.
  - -> sweep restarts at ptr=1.
  - -> init_busy stays high 31 cycles after deassertion.
- Parity (REGFILE_PARITY_EN): write 0x0F to reg 2, force-flip stored data bit 0, read reg 2 -> perr[0]=1, rdata=0x0E. Without the macro -> perr=0.
